// File: rtl/echo_indication_output.sv
// Indication-side encoder for the echo portal: buffers heard/heard2 calls in
// one-entry slots and packs them round-robin into tagged 192-bit pipe messages.
module echo_indication_output #(
    parameter logic [31:0] TAG_HEARD  = 32'd1,
    parameter logic [31:0] TAG_HEARD2 = 32'd2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         indication_heard__ENA,
    input  logic [31:0]  indication_heard_meth,
    input  logic [31:0]  indication_heard_v,
    output logic         indication_heard__RDY,
    input  logic         indication_heard2__ENA,
    input  logic [31:0]  indication_heard2_meth,
    input  logic [31:0]  indication_heard2_v,
    output logic         indication_heard2__RDY,
    output logic         pipe_enq__ENA,
    output logic [191:0] pipe_enq_v,
    input  logic         pipe_enq__RDY
);
    localparam int N = 2;

    // Index 0 is heard, index 1 is heard2.
    logic        ena [N];
    logic [31:0] meth [N];
    logic [31:0] v [N];
    logic        slot_valid [N];
    logic [63:0] slot_data [N];

    assign ena[0]  = indication_heard__ENA;
    assign meth[0] = indication_heard_meth;
    assign v[0]    = indication_heard_v;
    assign ena[1]  = indication_heard2__ENA;
    assign meth[1] = indication_heard2_meth;
    assign v[1]    = indication_heard2_v;

    logic         out_valid_reg;
    logic [191:0] out_data_reg;
    logic         last_grant_reg;   // slot index of the most recent load
    logic         grant_sel;
    logic         load;
    logic [191:0] packed_msg;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slot
            logic        valid_reg;
            logic [63:0] data_reg;

            // A slot is only ever filled while empty, so fill and drain never collide.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                end else if (ena[gi] && !valid_reg) begin
                    valid_reg <= 1'b1;
                    data_reg  <= {meth[gi], v[gi]};
                end else if (load && (grant_sel == 1'(gi))) begin
                    valid_reg <= 1'b0;
                end
            end

            assign slot_valid[gi] = valid_reg;
            assign slot_data[gi]  = data_reg;
        end
    endgenerate

    assign indication_heard__RDY  = !slot_valid[0];
    assign indication_heard2__RDY = !slot_valid[1];

    // On a tie the slot that did not win last time is chosen.
    always_comb begin
        grant_sel  = 1'b0;
        packed_msg = '0;
        load       = (!out_valid_reg || pipe_enq__RDY) && (slot_valid[0] || slot_valid[1]);
        if (slot_valid[1] && (!slot_valid[0] || !last_grant_reg)) begin
            grant_sel = 1'b1;
        end
        if (grant_sel) begin
            packed_msg = {32'd0, slot_data[1][31:0], slot_data[1][63:32], 64'd0, TAG_HEARD2};
        end else begin
            packed_msg = {96'd0, slot_data[0][31:0], slot_data[0][63:32], TAG_HEARD};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            last_grant_reg <= 1'b1;   // heard2 counts as last winner so heard takes the first tie
        end else if (load) begin
            out_valid_reg  <= 1'b1;
            out_data_reg   <= packed_msg;
            last_grant_reg <= grant_sel;
        end else if (out_valid_reg && pipe_enq__RDY) begin
            out_valid_reg  <= 1'b0;
        end
    end

    assign pipe_enq__ENA = out_valid_reg;
    assign pipe_enq_v    = out_data_reg;
endmodule

// File: tb/tb_echo_indication_output.sv
// Scoreboard bench for echo_indication_output: per-method expected queues are
// filled by the stimulus and drained by an independent output monitor.
module tb_echo_indication_output;
    localparam logic [31:0] TAG1 = 32'd1;
    localparam logic [31:0] TAG2 = 32'd2;

    logic         clk = 1'b0;
    logic         rst;
    logic         h_ena, h_rdy, h2_ena, h2_rdy;
    logic [31:0]  h_meth, h_v, h2_meth, h2_v;
    logic         enq_ena, enq_rdy;
    logic [191:0] enq_v;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [191:0] exp1_q [$];
    logic [191:0] exp2_q [$];
    int           tag_log [$];
    int           cyc_log [$];
    logic         prev_stall = 1'b0;
    logic [191:0] prev_v = '0;

    echo_indication_output #(.TAG_HEARD(TAG1), .TAG_HEARD2(TAG2)) dut (
        .CLK(clk),
        .RST(rst),
        .indication_heard__ENA(h_ena),
        .indication_heard_meth(h_meth),
        .indication_heard_v(h_v),
        .indication_heard__RDY(h_rdy),
        .indication_heard2__ENA(h2_ena),
        .indication_heard2_meth(h2_meth),
        .indication_heard2_v(h2_v),
        .indication_heard2__RDY(h2_rdy),
        .pipe_enq__ENA(enq_ena),
        .pipe_enq_v(enq_v),
        .pipe_enq__RDY(enq_rdy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference packing, written as field placement arithmetic.
    function automatic logic [191:0] pack1(input logic [31:0] m, input logic [31:0] v);
        return (192'(v) << 64) | (192'(m) << 32) | 192'(TAG1);
    endfunction

    function automatic logic [191:0] pack2(input logic [31:0] m, input logic [31:0] v);
        return (192'(v) << 128) | (192'(m) << 96) | 192'(TAG2);
    endfunction

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: every transfer pops the queue of the method named by its tag.
    always @(negedge clk) begin
        logic [31:0] tag;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_ena", 192'(enq_ena), 192'(1));
                chk("stall_data", enq_v, prev_v);
            end
            if (enq_ena && enq_rdy) begin
                tag = enq_v[31:0];
                $display("cycle %0d: transfer tag=%0d data=%0h", cyc, tag, enq_v);
                tag_log.push_back(int'(tag));
                cyc_log.push_back(cyc);
                if (tag == TAG1 && exp1_q.size() > 0) begin
                    chk("heard_msg", enq_v, exp1_q.pop_front());
                end else if (tag == TAG2 && exp2_q.size() > 0) begin
                    chk("heard2_msg", enq_v, exp2_q.pop_front());
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_msg: got %0h required no message", enq_v);
                end
            end
            prev_stall = enq_ena && !enq_rdy;
            prev_v     = enq_v;
        end
    end

    // One cycle of method stimulus; a call counts only if the slot was empty.
    task automatic step(input logic e1, input logic [31:0] m1, input logic [31:0] v1,
                        input logic e2, input logic [31:0] m2, input logic [31:0] v2);
        logic a1, a2;
        a1 = e1 && h_rdy;
        a2 = e2 && h2_rdy;
        h_ena = e1;  h_meth = m1;  h_v = v1;
        h2_ena = e2; h2_meth = m2; h2_v = v2;
        if (a1) begin
            exp1_q.push_back(pack1(m1, v1));
            $display("cycle %0d: call heard tag=%0d meth=%0h v=%0h", cyc, TAG1, m1, v1);
        end
        if (a2) begin
            exp2_q.push_back(pack2(m2, v2));
            $display("cycle %0d: call heard2 tag=%0d meth=%0h v=%0h", cyc, TAG2, m2, v2);
        end
        @(posedge clk);
        #1;
        h_ena = 1'b0;
        h2_ena = 1'b0;
        if (a1) chk("heard_rdy_after_call", 192'(h_rdy), 192'(0));
        if (a2) chk("heard2_rdy_after_call", 192'(h2_rdy), 192'(0));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must react before any edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_async_ena", 192'(enq_ena), 192'(0));
        chk("rst_async_rdy1", 192'(h_rdy), 192'(1));
        chk("rst_async_rdy2", 192'(h2_rdy), 192'(1));
        exp1_q.delete();
        exp2_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int n0, c0, c1, acc;
        rst = 1'b1;
        h_ena = 1'b1;  h_meth = 32'hdead; h_v = 32'hbeef;
        h2_ena = 1'b1; h2_meth = 32'hcafe; h2_v = 32'hf00d;
        enq_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ena", 192'(enq_ena), 192'(0));
        chk("reset_data", enq_v, 192'(0));
        chk("reset_rdy1", 192'(h_rdy), 192'(1));
        chk("reset_rdy2", 192'(h2_rdy), 192'(1));
        h_ena = 1'b0;
        h2_ena = 1'b0;
        rst = 1'b0;
        idle(3);
        chk("no_msg_after_reset", 192'(tag_log.size()), 192'(0));

        // Single call latency: ENA exactly two cycles after the call cycle.
        n0 = tag_log.size();
        c0 = cyc;
        step(1'b1, 32'd5, 32'h1234, 1'b0, 32'd0, 32'd0);
        idle(4);
        chk("latency_count", 192'(tag_log.size()), 192'(n0 + 1));
        chk("latency_cycle", 192'((tag_log.size() > n0) ? cyc_log[n0] : -1), 192'(c0 + 2));

        // Simultaneous calls after reset: heard first, then heard2.
        do_reset();
        n0 = tag_log.size();
        c0 = cyc;
        step(1'b1, 32'h11, 32'h22, 1'b1, 32'd7, 32'd9);
        idle(1);
        chk("tie_rdy1_back", 192'(h_rdy), 192'(1));
        chk("tie_rdy2_held", 192'(h2_rdy), 192'(0));
        idle(1);
        chk("tie_rdy2_back", 192'(h2_rdy), 192'(1));
        idle(3);
        chk("tie_count", 192'(tag_log.size()), 192'(n0 + 2));
        chk("tie_first_tag", 192'((tag_log.size() > n0) ? tag_log[n0] : 0), 192'(1));
        chk("tie_second_tag", 192'((tag_log.size() > n0 + 1) ? tag_log[n0 + 1] : 0), 192'(2));
        chk("tie_first_cycle", 192'((tag_log.size() > n0) ? cyc_log[n0] : -1), 192'(c0 + 2));
        chk("tie_second_cycle", 192'((tag_log.size() > n0 + 1) ? cyc_log[n0 + 1] : -1), 192'(c0 + 3));

        // Backpressure: slot drains into out, second call waits in the slot.
        do_reset();
        enq_rdy = 1'b0;
        n0 = tag_log.size();
        step(1'b0, 32'd0, 32'd0, 1'b1, 32'haaaa, 32'hbbbb);
        idle(1);
        chk("bp_rdy2_after_drain", 192'(h2_rdy), 192'(1));
        chk("bp_ena_up", 192'(enq_ena), 192'(1));
        step(1'b0, 32'd0, 32'd0, 1'b1, 32'hcccc, 32'hdddd);
        idle(8);
        chk("bp_rdy2_holding", 192'(h2_rdy), 192'(0));
        chk("bp_no_transfer", 192'(tag_log.size()), 192'(n0));
        enq_rdy = 1'b1;
        c1 = cyc;
        idle(4);
        chk("bp_release_count", 192'(tag_log.size()), 192'(n0 + 2));
        chk("bp_release_first", 192'((tag_log.size() > n0) ? cyc_log[n0] : -1), 192'(c1));
        chk("bp_back_to_back", 192'((tag_log.size() > n0 + 1) ? cyc_log[n0 + 1] : -1), 192'(c1 + 1));

        // Single heard grant, then continuous refills: ties resolve to heard2 first.
        do_reset();
        step(1'b1, 32'h1, 32'h2, 1'b0, 32'd0, 32'd0);
        idle(4);
        n0 = tag_log.size();
        for (int i = 0; i < 12; i++) begin
            step(h_rdy, $urandom, $urandom, h2_rdy, $urandom, $urandom);
        end
        idle(5);
        chk("rr_progress", 192'(tag_log.size() >= n0 + 10), 192'(1));
        for (int k = n0; k < tag_log.size(); k++) begin
            chk("rr_alternate", 192'(tag_log[k]), 192'((((k - n0) % 2) == 0) ? 2 : 1));
        end

        // Reset with both slots and out occupied discards everything.
        do_reset();
        enq_rdy = 1'b0;
        step(1'b1, 32'h31, 32'h32, 1'b1, 32'h41, 32'h42);
        idle(2);
        step(1'b1, 32'h51, 32'h52, 1'b0, 32'd0, 32'd0);
        chk("pre_reset_full", 192'({enq_ena, h_rdy, h2_rdy}), 192'(3'b100));
        do_reset();
        enq_rdy = 1'b1;
        n0 = tag_log.size();
        idle(6);
        chk("post_reset_silent", 192'(tag_log.size()), 192'(n0));

        // Call while slot full is ignored.
        do_reset();
        enq_rdy = 1'b0;
        n0 = tag_log.size();
        step(1'b1, 32'h61, 32'h62, 1'b0, 32'd0, 32'd0);
        step(1'b1, 32'h71, 32'h72, 1'b0, 32'd0, 32'd0);
        idle(1);
        enq_rdy = 1'b1;
        idle(4);
        chk("violation_count", 192'(tag_log.size()), 192'(n0 + 1));

        // Random traffic with random backpressure and protocol violations.
        do_reset();
        acc = 0;
        for (int i = 0; i < 400; i++) begin
            enq_rdy = ($urandom_range(0, 3) != 0);
            step(1'($urandom), $urandom, $urandom, 1'($urandom), $urandom, $urandom);
        end
        enq_rdy = 1'b1;
        idle(10);
        acc = exp1_q.size() + exp2_q.size();
        chk("random_drained", 192'(acc), 192'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/echo_indication_output.md
Name: echo_indication_output

Overview:
- Encoder for the indication direction of the echo portal.
- Accepts `heard` and `heard2` method calls (each with a 32-bit meth and a 32-bit v) and packs them into tagged 192-bit messages on an outbound `pipe$enq` interface.
- The packed format is exactly the one the request-side decoder unpacks.
- Each method has a one-entry holding slot. A round-robin arbiter drains the slots into a registered output stage that absorbs `pipe$enq__RDY` backpressure.

Parameters:
- TAG_HEARD, 1, tag value placed in bits [31:0] for `heard` messages.
- TAG_HEARD2, 2, tag value placed in bits [31:0] for `heard2` messages.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- indication$heard__ENA  input  1  `heard` call valid.
- indication$heard$meth  input  32  `heard` meth argument.
- indication$heard$v  input  32  `heard` v argument.
- indication$heard__RDY  output  1  `heard` slot empty.
- indication$heard2__ENA  input  1  `heard2` call valid.
- indication$heard2$meth  input  32  `heard2` meth argument.
- indication$heard2$v  input  32  `heard2` v argument.
- indication$heard2__RDY  output  1  `heard2` slot empty.
- pipe$enq__ENA  output  1  outbound message valid.
- pipe$enq$v  output  192  outbound packed message.
- pipe$enq__RDY  input  1  downstream can accept.

Behaviour:
- Reset (async, RST high):
  - slot1/slot2 valid=0, data=0.
  - Output register valid=0, data=0.
  - last_grant=2, so `heard` wins the first tie.
  - While RST is high: pipe$enq__ENA=0, pipe$enq$v=0, both __RDY=1; all ENA inputs are ignored.
- Method RDY:
  - indication$heardN__RDY = !slotN.valid.
  - Driven purely from registers; never depends on any ENA.
- Method execute:
  - Fires when heardN__ENA & heardN__RDY.
  - At that edge slotN captures {meth, v} and slotN.valid is set.
  - ENA asserted while RDY=0 is a protocol violation: ignored, slot unchanged.
- Output transfer:
  - pipe$enq__ENA = out.valid; pipe$enq$v = out.data.
  - A transfer occurs on a cycle with ENA & RDY.
  - out holds value and valid stable until transferred.
- Load condition: out loads when (!out.valid | transfer) and at least one slot is valid.
  - This gives full throughput: the output can reload on the same edge it transfers.
- Arbitration:
  - Only slot1 valid -> grant 1; only slot2 valid -> grant 2.
  - Both valid -> grant the slot != last_grant.
  - last_grant updates only on an actual load.
  - The granted slot's valid clears on the load edge.
  - That slot's RDY returns to 1 in the next cycle. A slot refill earliest one cycle after its drain.
- Packing (all unused bits zero):
  - Grant 1: [31:0]=TAG_HEARD, [63:32]=meth, [95:64]=v, [191:96]=0.
  - Grant 2: [31:0]=TAG_HEARD2, [63:32]=0, [95:64]=0, [127:96]=meth, [159:128]=v, [191:160]=0.
- Latency with no backpressure:
  - Call executes at edge t; the slot is visible in cycle t+1; out loads at edge t+1.
  - pipe$enq__ENA is high in cycle t+2 (2 cycles).
- Simultaneous events:
  - Both methods in the same cycle are both accepted, then emitted in round-robin order on consecutive cycles.
  - A new call to slot N while out is stalled waits in the slot; only one message per method is buffered beyond out.
- Reset mid-operation: all pending slot and out contents are discarded; no partial message is emitted after RST deasserts.
- Simulation only: on each method execute, `$display` the method name and the tag.

Test Plan:
- Reset, then `heard`(meth=5, v=0x1234) with pipe$enq__RDY=1:
  - ENA high exactly 2 cycles later, one cycle wide.
  - v[31:0]=1, [63:32]=5, [95:64]=0x1234, other bits 0.
- `heard` and `heard2` (meth=7, v=9) in the same cycle, RDY=1:
  - Consecutive messages, tag 1 then tag 2.
  - Second has [127:96]=7, [159:128]=9, [95:32]=0.
  - Both RDYs low for exactly the cycles their slots hold data.
- Hold pipe$enq__RDY=0 for 10 cycles after one `heard2` call:
  - ENA and v stay stable throughout.
  - `heard2`__RDY returns 1 after the slot drains into out; a second `heard2` call is held in the slot.
  - Release RDY -> two back-to-back transfers.
- Continuous alternating ties with RDY=1:
  - Output tags alternate 1,2,1,2; no starvation.
  - last_grant is correct after the single-slot grants that precede the ties.
- Assert RST with both slots and out valid:
  - ENA drops immediately (async) and both __RDY=1.
  - After deassert, no message appears without a new call.
- Drive ENA while RDY=0:
  - Slot contents unchanged.
  - Output sequence unaffected.
